// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit with SPARC-style delayed branching.
// It walks FETCH -> WAIT -> HOLD for every instruction. An MFC timeout
// parks the unit in ERROR until reset.
// Handshake: RAM_enable stays high through FETCH and WAIT. The word on
// RAM_data_in is taken on the first WAIT cycle that has MFC=1. IR_Enable
// marks a valid instruction in HOLD. The instruction is consumed on the
// first HOLD cycle that has ir_ready=1.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          WAIT_LIMIT   = 15,
  parameter logic [5:0]  READ_WORD_OP = 6'b000000
) (
  input  logic        Clk,
  input  logic        RESET,
  input  logic [31:0] RAM_data_in,
  input  logic        MFC,
  input  logic        ir_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        RAM_enable,
  output logic [5:0]  RAM_OpCode,
  output logic [31:0] RAM_address,
  output logic [31:0] IR_Out,
  output logic        IR_Enable,
  output logic [31:0] PC_Out,
  output logic [31:0] NPC_Out,
  output logic        fetch_error,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    ERROR = 2'd3
  } state_t;

  localparam int CW = $clog2(WAIT_LIMIT + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(WAIT_LIMIT - 1);

  state_t         state;
  logic [CW-1:0]  wait_cnt;
  logic           pend_valid;
  logic [31:0]    pend_target;
  logic [31:0]    target_aligned;
  logic [31:0]    next_npc;

  assign RAM_OpCode     = READ_WORD_OP;
  assign fsm_state      = state;
  assign target_aligned = {branch_target[31:2], 2'b00};

  // Successor of the new NPC on an advance. A branch arriving in the same
  // cycle beats an older pending one. Otherwise the flow is sequential,
  // and it wraps modulo 2^32.
  always_comb begin
    next_npc = NPC_Out + 32'd4;
    if (branch_taken) begin
      next_npc = target_aligned;
    end else if (pend_valid) begin
      next_npc = pend_target;
    end
  end

  // Fetch state machine, program counters, pending redirect and registered outputs.
  always_ff @(posedge Clk or posedge RESET) begin
    if (RESET) begin
      state       <= FETCH;
      PC_Out      <= RESET_PC;
      NPC_Out     <= RESET_PC + 32'd4;
      IR_Out      <= 32'd0;
      IR_Enable   <= 1'b0;
      pend_valid  <= 1'b0;
      pend_target <= 32'd0;
      wait_cnt    <= '0;
      fetch_error <= 1'b0;
      RAM_enable  <= 1'b0;
      RAM_address <= RESET_PC;
    end else begin
      // Redirect requests are remembered until the next advance. A newer
      // request replaces an older one.
      if (state != ERROR && branch_taken) begin
        pend_valid  <= 1'b1;
        pend_target <= target_aligned;
      end
      case (state)
        FETCH: begin
          RAM_enable  <= 1'b1;
          RAM_address <= PC_Out;
          wait_cnt    <= '0;
          state       <= WAIT;
        end
        WAIT: begin
          if (MFC) begin
            IR_Out     <= RAM_data_in;
            IR_Enable  <= 1'b1;
            RAM_enable <= 1'b0;
            wait_cnt   <= '0;
            state      <= HOLD;
          end else if (wait_cnt == LAST_WAIT) begin
            fetch_error <= 1'b1;
            RAM_enable  <= 1'b0;
            state       <= ERROR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (ir_ready) begin
            // The old NPC becomes the new PC (the delay slot). The redirect
            // target, if any, becomes the NPC after that.
            PC_Out      <= NPC_Out;
            NPC_Out     <= next_npc;
            pend_valid  <= 1'b0;
            IR_Enable   <= 1'b0;
            RAM_enable  <= 1'b1;
            RAM_address <= NPC_Out;
            state       <= FETCH;
          end
        end
        default: begin
          // ERROR: frozen until reset.
        end
      endcase
    end
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000: address of first fetch after reset.
REQ-002 SHALL have parameter WAIT_LIMIT, default 15: maximum cycles spent waiting for MFC per fetch.
REQ-003 SHALL have parameter READ_WORD_OP, default 6'b000000: RAM_OpCode value for a word read.
REQ-004 SHALL have port Clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port RAM_data_in  input  32  instruction word returned by RAM.
REQ-007 SHALL have port MFC  input  1  memory-function-complete; RAM_data_in valid while high.
REQ-008 SHALL have port ir_ready  input  1  control unit accepts the presented instruction this cycle.
REQ-009 SHALL have port branch_taken  input  1  one-cycle redirect request.
REQ-010 SHALL have port branch_target  input  32  redirect address; bits [1:0] ignored, forced 00.
REQ-011 SHALL have port RAM_enable, RAM_OpCode (6), RAM_address (32)  output  fetch request to RAM.
REQ-012 SHALL have port IR_Out  output  32  fetched instruction; IR_Enable  output  1  IR_Out valid.
REQ-013 SHALL have port PC_Out, NPC_Out  output  32 each  address of presented instruction and its successor.
REQ-014 SHALL have port fetch_error  output  1  sticky MFC-timeout flag.

Function
REQ-015 SHALL implement states FETCH, WAIT, HOLD, ERROR (2-bit encoding).
REQ-016 SHALL, in FETCH, drive RAM_enable=1, RAM_address=PC, RAM_OpCode=READ_WORD_OP, and go to WAIT next cycle.
REQ-017 SHALL, in WAIT, keep RAM_enable=1 and RAM_address=PC; on MFC=1 latch RAM_data_in into IR_Out and go to HOLD.
REQ-018 SHALL count WAIT cycles with MFC=0; on the WAIT_LIMIT-th such cycle go to ERROR, set fetch_error=1.
REQ-019 SHALL drive RAM_enable=0 in HOLD and ERROR.
REQ-020 SHALL assert IR_Enable=1 only in HOLD; IR_Out, PC_Out, NPC_Out stable throughout HOLD.
REQ-021 SHALL, in HOLD with ir_ready=1, advance: PC<=NPC; NPC<=redirect target if one is pending, else NPC+4; clear pending; go to FETCH.
REQ-022 SHALL give SPARC delayed-branch semantics: instruction at old NPC (delay slot) always fetched before target.
REQ-023 SHALL latch branch_taken/branch_target into a pending register in any non-ERROR state; later request overwrites earlier.
REQ-024 SHALL, when branch_taken and advance coincide, use the new branch_target for that advance.
REQ-025 SHALL compute NPC+4 modulo 2^32 (FFFFFFFC wraps to 00000000).
REQ-026 SHALL, when MFC=1 arrives on the WAIT_LIMIT-th cycle, treat the fetch as successful (HOLD, no error).
REQ-027 SHALL ignore MFC outside WAIT and ir_ready outside HOLD.
REQ-028 SHALL remain in ERROR, ignoring all inputs except RESET.
REQ-029 SHALL have minimum latency FETCH->HOLD of 2 cycles (MFC high first WAIT cycle); throughput one instruction per 3 cycles with ir_ready held high.

Reset
REQ-030 SHALL, while RESET=1, asynchronously set state=FETCH, PC=RESET_PC, NPC=RESET_PC+4, IR_Out=0, IR_Enable=0, pending cleared, wait counter=0, fetch_error=0, RAM_enable=0, RAM_address=RESET_PC, RAM_OpCode=READ_WORD_OP.
REQ-031 SHALL, on RESET mid-fetch, abandon the access; a late MFC after release is ignored unless in WAIT.
REQ-032 SHALL begin the first fetch on the first rising Clk edge after RESET deasserts.

Verification
REQ-033 SHALL verify sequential fetch: RAM returns words at 0,4,8 with MFC after 1 cycle, ir_ready=1 -> IR_Out sequence matches, PC_Out 0,4,8, IR_Enable one cycle each 3.
REQ-034 SHALL verify delayed branch: branch_taken with target 0x40 while presenting PC=0x10 -> next PC_Out 0x14, then 0x40, 0x44.
REQ-035 SHALL verify backpressure: ir_ready=0 for 5 cycles in HOLD -> IR_Out/PC_Out unchanged, RAM_enable=0, no fetch issued.
REQ-036 SHALL verify timeout: MFC never asserted -> fetch_error=1 after 15 WAIT cycles, RAM_enable=0, stuck until RESET; MFC on cycle 15 -> HOLD, fetch_error=0.
REQ-037 SHALL verify wrap: NPC=0xFFFFFFFC advanced -> NPC_Out=0x00000000.
REQ-038 SHALL verify async reset in WAIT: RESET pulse mid-cycle -> outputs at reset values immediately, refetch from RESET_PC.
